// File: rtl/seq_mac_arbiter_if.sv
// Bundle of requester-side and MAC-side signals for seq_mac_arbiter.
// Signal suffixes (_i/_o) are named from the arbiter's point of view.
interface seq_mac_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int K         = 2,
  parameter int MAX_WIDTH = 16
);
  localparam int VW = K * MAX_WIDTH;
  localparam int DW = 2 * MAX_WIDTH;

  logic        [NUM_REQ-1:0]    req_valid_i;
  logic        [NUM_REQ-1:0]    req_ready_o;
  logic signed [NUM_REQ*VW-1:0] req_row_i;
  logic signed [NUM_REQ*VW-1:0] req_column_i;
  logic signed [NUM_REQ*DW-1:0] req_c_i;
  logic        [NUM_REQ*5-1:0]  req_bitsize_i;
  logic        [NUM_REQ-1:0]    resp_valid_o;
  logic        [NUM_REQ-1:0]    resp_ready_i;
  logic signed [DW-1:0]         resp_data_o;
  logic                         resp_err_o;
  logic signed [VW-1:0]         mac_row_o;
  logic signed [VW-1:0]         mac_column_o;
  logic signed [DW-1:0]         mac_c_o;
  logic        [4:0]            mac_bitsize_o;
  logic                         mac_valid_o;
  logic                         mac_ready_i;
  logic                         mac_valid_i;
  logic                         mac_ready_o;
  logic signed [DW-1:0]         mac_result_i;

  modport slave (
    input  req_valid_i, req_row_i, req_column_i, req_c_i, req_bitsize_i, resp_ready_i,
           mac_ready_i, mac_valid_i, mac_result_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
           mac_row_o, mac_column_o, mac_c_o, mac_bitsize_o, mac_valid_o, mac_ready_o
  );

  modport master (
    output req_valid_i, req_row_i, req_column_i, req_c_i, req_bitsize_i, resp_ready_i,
           mac_ready_i, mac_valid_i, mac_result_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
           mac_row_o, mac_column_o, mac_c_o, mac_bitsize_o, mac_valid_o, mac_ready_o
  );
endinterface

// File: rtl/seq_mac_arbiter.sv
// Round-robin arbiter sharing one sequential multiply-adder among NUM_REQ requesters,
// with a single outstanding operation, bitsize screening and a WAIT timeout.
module seq_mac_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int K         = 2,
  parameter int MAX_WIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  seq_mac_arbiter_if.slave bus
);
  localparam int VW = K * MAX_WIDTH;
  localparam int DW = 2 * MAX_WIDTH;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             r_state, w_state_next;
  logic [PW-1:0]      r_rr_ptr, r_owner, w_grant_idx, w_cand;
  logic [PW:0]        w_sum;
  logic               w_grant_found, w_grant_legal;
  logic [CW-1:0]      r_cnt;
  logic [DW-1:0]      r_data, r_c;
  logic               r_err;
  logic [VW-1:0]      r_row, r_col;
  logic [4:0]         r_bitsize;
  logic [NUM_REQ-1:0] w_req_ready, w_resp_valid;
  logic               w_mac_valid, w_mac_ready;

  logic [VW-1:0] w_row [NUM_REQ];
  logic [VW-1:0] w_col [NUM_REQ];
  logic [DW-1:0] w_c   [NUM_REQ];
  logic [4:0]    w_bs  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_row[gi] = bus.req_row_i[gi*VW +: VW];
    assign w_col[gi] = bus.req_column_i[gi*VW +: VW];
    assign w_c[gi]   = bus.req_c_i[gi*DW +: DW];
    assign w_bs[gi]  = bus.req_bitsize_i[gi*5 +: 5];
  end

  function automatic logic legal_bitsize(input logic [4:0] b);
    return ((b == 5'd2) || (b == 5'd4) || (b == 5'd8) || (b == 5'd16)) &&
           (int'(b) <= MAX_WIDTH);
  endfunction

  // Walk downward so the lowest offset from r_rr_ptr wins the last assignment.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_sum         = '0;
    w_cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NUM_REQ)) w_sum = w_sum - (PW+1)'(NUM_REQ);
      w_cand = w_sum[PW-1:0];
      if (bus.req_valid_i[w_cand]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  assign w_grant_legal = legal_bitsize(w_bs[w_grant_idx]);

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = '0;
    w_resp_valid = '0;
    w_mac_valid  = 1'b0;
    w_mac_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        w_mac_ready = 1'b1;  // drain a result arriving after a timeout
        if (w_grant_found) begin
          w_req_ready[w_grant_idx] = 1'b1;
          w_state_next = w_grant_legal ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        w_mac_valid = 1'b1;
        if (bus.mac_ready_i) w_state_next = WAIT;
      end
      WAIT: begin
        w_mac_ready = 1'b1;
        if (bus.mac_valid_i || (r_cnt == CW'(TIMEOUT))) w_state_next = RESP;
      end
      RESP: begin
        w_resp_valid[r_owner] = 1'b1;
        if (bus.resp_ready_i[r_owner]) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_c       <= '0;
      r_bitsize <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_grant_found) begin
            r_owner   <= w_grant_idx;
            r_row     <= w_row[w_grant_idx];
            r_col     <= w_col[w_grant_idx];
            r_c       <= w_c[w_grant_idx];
            r_bitsize <= w_bs[w_grant_idx];
            if (!w_grant_legal) begin
              r_err  <= 1'b1;
              r_data <= '0;
            end
          end
        end
        ISSUE: begin
          if (bus.mac_ready_i) r_cnt <= '0;
        end
        WAIT: begin
          // A result in the timeout cycle still counts as a good response.
          if (bus.mac_valid_i) begin
            r_data <= bus.mac_result_i;
            r_err  <= 1'b0;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_data <= '0;
            r_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready_i[r_owner])
            r_rr_ptr <= (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o   = rst_i ? '0 : w_req_ready;
  assign bus.resp_valid_o  = rst_i ? '0 : w_resp_valid;
  assign bus.mac_valid_o   = rst_i ? 1'b0 : w_mac_valid;
  assign bus.mac_ready_o   = rst_i ? 1'b0 : w_mac_ready;
  assign bus.resp_data_o   = r_data;
  assign bus.resp_err_o    = r_err;
  assign bus.mac_row_o     = r_row;
  assign bus.mac_column_o  = r_col;
  assign bus.mac_c_o       = r_c;
  assign bus.mac_bitsize_o = r_bitsize;
endmodule
